// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the fetch unit: opcode encoding, FSM states, PC/IR sizes.
package typedefs;

  localparam int PC_WIDTH = 5;
  localparam int IR_WIDTH = 8;

  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Control/data bundle between the sequencer and the fetch unit.
// FETCH_INSTR_CNT_EN adds the instr_cnt output.
interface fetch_unit_if;
  import typedefs::*;

  logic                 load_ir;
  logic                 inc_pc;
  logic                 load_pc;
  logic                 halt;
  logic                 sel_pc;
  logic [IR_WIDTH-1:0]  data_in;
  opcode_t              opcode;
  logic [PC_WIDTH-1:0]  ir_addr;
  logic [PC_WIDTH-1:0]  pc;
  logic [PC_WIDTH-1:0]  addr;
  logic                 halted;
`ifdef FETCH_INSTR_CNT_EN
  logic [15:0]          instr_cnt;

  modport master (
    output load_ir, inc_pc, load_pc, halt, sel_pc, data_in,
    input  opcode, ir_addr, pc, addr, halted, instr_cnt
  );
  modport slave (
    input  load_ir, inc_pc, load_pc, halt, sel_pc, data_in,
    output opcode, ir_addr, pc, addr, halted, instr_cnt
  );
`else
  modport master (
    output load_ir, inc_pc, load_pc, halt, sel_pc, data_in,
    input  opcode, ir_addr, pc, addr, halted
  );
  modport slave (
    input  load_ir, inc_pc, load_pc, halt, sel_pc, data_in,
    output opcode, ir_addr, pc, addr, halted
  );
`endif

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: loadable, enable-gated, wraps modulo 2**WIDTH, synchronous reset.
module pc_counter
  import typedefs::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Load wins over increment; the increment simply rolls over at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_count <= i_load_val;
      end else if (i_inc) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: IR capture, PC sequencing, address mux and RUN/HALTED control.
// Optional macro FETCH_INSTR_CNT_EN adds a saturating 16-bit count of IR loads.
//
// state  | meaning
// RUN    | IR/PC respond to load_ir, inc_pc, load_pc
// HALTED | IR/PC frozen; only rst leaves this state
module fetch_unit
  import typedefs::*;
(
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.slave  bus
);

  fetch_state_t         r_state;
  fetch_state_t         w_state_nxt;
  logic                 w_run;
  logic                 w_halted;
  logic [IR_WIDTH-1:0]  r_ir;
  logic [PC_WIDTH-1:0]  w_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN && bus.halt) begin
      w_state_nxt = HALTED;
    end
  end

  always_comb begin
    w_run    = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      RUN:     w_run    = 1'b1;
      HALTED:  w_halted = 1'b1;
      default: w_halted = 1'b0;
    endcase
  end

  // The halt cycle itself still updates IR/PC because w_run reflects the pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir <= '0;
    end else if (w_run && bus.load_ir) begin
      r_ir <= bus.data_in;
    end
  end

  pc_counter #(
    .WIDTH (PC_WIDTH)
  ) u_pc_counter (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_run),
    .i_load     (bus.load_pc),
    .i_inc      (bus.inc_pc),
    .i_load_val (r_ir[PC_WIDTH-1:0]),
    .o_count    (w_pc)
  );

  assign bus.opcode  = opcode_t'(r_ir[IR_WIDTH-1:PC_WIDTH]);
  assign bus.ir_addr = r_ir[PC_WIDTH-1:0];
  assign bus.pc      = w_pc;
  assign bus.addr    = bus.sel_pc ? w_pc : r_ir[PC_WIDTH-1:0];
  assign bus.halted  = w_halted;

`ifdef FETCH_INSTR_CNT_EN
  logic [15:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_cnt <= '0;
    end else if (w_run && bus.load_ir && r_instr_cnt != 16'hFFFF) begin
      r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end

  assign bus.instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: abstract model checked every cycle plus literal spot checks.
module tb_fetch_unit;
  import typedefs::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the spec says PC/IR/halted/count must be.
  logic [4:0]  m_pc;
  logic [7:0]  m_ir;
  bit          m_halted;
  bit          m_valid = 1'b0;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 5'd0;
      m_ir = 8'h00;
      m_halted = 1'b0;
      m_cnt = 0;
      m_valid = 1'b1;
    end else if (m_valid && !m_halted) begin
      if (bus.load_pc)     m_pc = m_ir[4:0];
      else if (bus.inc_pc) m_pc = 5'((m_pc + 1) % 32);
      if (bus.load_ir) begin
        m_ir = bus.data_in;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if (bus.halt) m_halted = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc",      16'(bus.pc),      16'(m_pc));
      chk("opcode",  16'(bus.opcode),  16'(m_ir[7:5]));
      chk("ir_addr", 16'(bus.ir_addr), 16'(m_ir[4:0]));
      chk("halted",  16'(bus.halted),  16'(m_halted));
      chk("addr",    16'(bus.addr),    16'(bus.sel_pc ? m_pc : m_ir[4:0]));
`ifdef FETCH_INSTR_CNT_EN
      chk("instr_cnt", bus.instr_cnt, 16'(m_cnt));
`endif
    end
  end

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic drive(input bit li, input bit ip, input bit lp, input bit h,
                       input logic [7:0] d, input bit r = 1'b0);
    rst         = r;
    bus.load_ir = li;
    bus.inc_pc  = ip;
    bus.load_pc = lp;
    bus.halt    = h;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    bus.load_ir = 0; bus.inc_pc = 0; bus.load_pc = 0; bus.halt = 0;
    bus.sel_pc = 1; bus.data_in = 8'h00;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 8'h00, 1);

    // reset state
    chk("rst_pc",     16'(bus.pc), 16'd0);
    chk("rst_opcode", 16'(bus.opcode), 16'(HLT));
    chk("rst_iraddr", 16'(bus.ir_addr), 16'd0);
    chk("rst_halted", 16'(bus.halted), 16'd0);
    chk("rst_addr",   16'(bus.addr), 16'd0);

    // IR load, then PC load from operand
    drive(1, 0, 0, 0, 8'hA7);
    chk("a7_opcode", 16'(bus.opcode), 16'h5);
    chk("a7_iraddr", 16'(bus.ir_addr), 16'd7);
    drive(0, 0, 1, 0, 8'h00);
    chk("a7_pc", 16'(bus.pc), 16'd7);
    bus.sel_pc = 0; #1;
    chk("a7_addr_ir", 16'(bus.addr), 16'd7);
    bus.sel_pc = 1;

    // wrap 31 -> 0
    drive(1, 0, 0, 0, 8'h1F);
    drive(0, 0, 1, 0, 8'h00);
    chk("pc31", 16'(bus.pc), 16'd31);
    drive(0, 1, 0, 0, 8'h00);
    chk("wrap", 16'(bus.pc), 16'd0);

    // load_pc beats inc_pc
    drive(1, 0, 0, 0, 8'h04);
    drive(0, 0, 1, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h09);
    chk("pc4", 16'(bus.pc), 16'd4);
    drive(0, 1, 1, 0, 8'h00);
    chk("prio_pc", 16'(bus.pc), 16'd9);

    // load_pc uses pre-edge IR while IR reloads
    drive(1, 0, 0, 0, 8'h05);
    drive(1, 0, 1, 0, 8'h1C);
    chk("same_pc", 16'(bus.pc), 16'd5);
    chk("same_ir_op", 16'(bus.opcode), 16'h0);
    chk("same_ir_addr", 16'(bus.ir_addr), 16'h1C);

    // mixed vectors with sel_pc toggling
    for (int i = 0; i < 8; i++) begin
      bus.sel_pc = i[0];
      drive(i[1], i[0], i[2] & i[0], 0, 8'(8'h31 * i + 3));
    end
    bus.sel_pc = 1;

    // rst mid-operation overrides strobes
    drive(1, 1, 0, 0, 8'hEE, 1);
    chk("midrst_pc", 16'(bus.pc), 16'd0);
    chk("midrst_ir", 16'(bus.ir_addr), 16'd0);

    // halt cycle still applies inc; then frozen
    drive(1, 0, 0, 0, 8'h03);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 1, 0, 1, 8'h00);
    chk("halt_pc", 16'(bus.pc), 16'd4);
    chk("halt_flag", 16'(bus.halted), 16'd1);
    for (int i = 0; i < 5; i++) begin
      bus.sel_pc = i[0];
      drive(i[0], !i[0], i[1], 0, 8'hF0 + 8'(i));
    end
    bus.sel_pc = 1;
    chk("frozen_pc", 16'(bus.pc), 16'd4);
    chk("frozen_ir", 16'(bus.ir_addr), 16'd3);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("unhalt_pc", 16'(bus.pc), 16'd0);
    chk("unhalt_flag", 16'(bus.halted), 16'd0);
    drive(0, 1, 0, 0, 8'h00);
    chk("post_rst_run", 16'(bus.pc), 16'd1);

`ifdef FETCH_INSTR_CNT_EN
    drive(0, 0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 8'h40 + 8'(i));
      idle();
    end
    drive(0, 0, 0, 1, 8'h00);
    drive(1, 0, 0, 0, 8'h77);
    drive(1, 0, 0, 0, 8'h78);
    chk("cnt3", bus.instr_cnt, 16'd3);
    drive(0, 0, 0, 0, 8'h00, 1);
    chk("cnt_rst", bus.instr_cnt, 16'd0);
    force dut.r_instr_cnt = 16'hFFFF;
    m_cnt = 65535;
    #1;
    release dut.r_instr_cnt;
    drive(1, 0, 0, 0, 8'h12);
    chk("cnt_sat", bus.instr_cnt, 16'hFFFF);
`endif

    idle();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-high: clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 load_ir  input  1  capture data_in into instruction register (IR).
REQ-005 inc_pc  input  1  increment program counter (PC).
REQ-006 load_pc  input  1  load PC from IR operand field.
REQ-007 halt  input  1  request transition to HALTED.
REQ-008 sel_pc  input  1  address select: 1 = PC drives addr, 0 = IR operand drives addr.
REQ-009 data_in  input  8  memory read data.
REQ-010 opcode  output  opcode_t  IR[7:5].
REQ-011 ir_addr  output  5  IR[4:0].
REQ-012 pc  output  5  current PC.
REQ-013 addr  output  5  memory address, combinational mux of pc / ir_addr per sel_pc.
REQ-014 halted  output  1  high while FSM is HALTED.

Function
REQ-015 FSM SHALL have two states, RUN and HALTED; RUN->HALTED when halt=1 at a rising edge; HALTED exits only via rst.
REQ-016 In RUN, PC update priority SHALL be load_pc (PC <= IR[4:0]) over inc_pc (PC <= PC+1) over hold, taking effect at the next rising edge.
REQ-017 PC increment SHALL be 5-bit modulo: 31 + 1 = 0, no flag.
REQ-018 In RUN, load_ir=1 SHALL write IR <= data_in at the next edge; load_ir and a PC update in the same cycle SHALL both apply; load_pc uses the pre-edge IR value.
REQ-019 In HALTED, PC and IR SHALL hold regardless of load_ir, inc_pc, load_pc.
REQ-020 A cycle with halt=1 in RUN SHALL still apply that cycle's load_ir/inc_pc/load_pc; freezing starts from the following cycle.
REQ-021 addr SHALL follow sel_pc combinationally with zero latency, in both states.
REQ-022 opcode, ir_addr, pc SHALL be direct register outputs (one-cycle latency from the load strobe).

Reset
REQ-023 rst=1 at a rising edge SHALL set PC=0, IR=8'h00 (opcode=HLT, ir_addr=0), state=RUN, halted=0, overriding all other inputs that cycle.
REQ-024 rst asserted mid-operation or in HALTED SHALL give the identical reset state; the first edge after rst deasserts behaves as normal RUN.

Configuration
REQ-025 With macro FETCH_INSTR_CNT_EN defined, the module SHALL add output instr_cnt (16 bits) counting IR loads in RUN, reset to 0, saturating at 16'hFFFF; IR loads ignored in HALTED are not counted.
REQ-026 Without FETCH_INSTR_CNT_EN, instr_cnt and its counter SHALL not exist; all other behaviour is unchanged.

Structure
REQ-027 opcode_t (existing), new fetch_state_t {RUN, HALTED}, and constants PC_WIDTH=5, IR_WIDTH=8 SHALL reside in package typedefs.
REQ-028 The PC SHALL be a sub-module pc_counter (loadable, enabled, wrapping, sync reset), instantiated once.

Verification
REQ-029 rst=1 one edge -> pc=0, IR=8'h00, opcode=HLT, halted=0; with sel_pc=1, addr=0.
REQ-030 data_in=8'hA7, load_ir=1 one edge -> opcode=3'b101, ir_addr=5'd7; then load_pc=1 -> pc=7; sel_pc=0 -> addr=7.
REQ-031 pc=31, inc_pc=1 -> pc=0; pc=4 with load_pc=1 and inc_pc=1, ir_addr=9 -> pc=9.
REQ-032 halt=1 with inc_pc=1 at pc=3 -> pc=4, halted=1; following 5 cycles of inc_pc/load_ir toggling -> pc=4, IR unchanged; rst -> pc=0, halted=0.
REQ-033 IR=8'h05, load_ir=1 with data_in=8'h1C and load_pc=1 same edge -> pc=5, IR=8'h1C.
REQ-034 FETCH_INSTR_CNT_EN defined: 3 load_ir pulses, then halt, then 2 load_ir -> instr_cnt=3; rst -> 0; saturation forced to 16'hFFFF stays at 16'hFFFF on a further load.
